// File: rtl/cache_control_nway.sv
// Control FSM for a WAYS-way write-back, write-allocate cache; owns the per-set tree PLRU.
// Define CACHE_CTRL_PERF_CNT_EN to add the hit_cnt/miss_cnt/wb_cnt performance counters.
module cache_control_nway #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 8,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WAY_W-1:0] way_sel,
  output logic [WAYS-1:0]  data_we,
  output logic             data_src,
  output logic [WAYS-1:0]  tag_load,
  output logic [WAYS-1:0]  valid_load,
  output logic [WAYS-1:0]  dirty_load,
  output logic             dirty_in,
`ifdef CACHE_CTRL_PERF_CNT_EN
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
  output logic [31:0]      wb_cnt,
`endif
  output logic             pmem_addr_sel
);

  localparam int unsigned PLRU_W = WAYS - 1;
  localparam int unsigned NODE_W = WAY_W + 1;

  typedef enum logic [1:0] {StCompare, StWriteBack, StAllocate} state_e;

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [PLRU_W-1:0] plru_q [SETS];
  logic [PLRU_W-1:0] plru_d;
  logic              plru_we;

  logic              req;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_way, miss_way;
  logic [WAYS-1:0]   hit_oh, vic_oh;
  logic [2*WAYS-1:0] tree, tree_upd;
  logic [NODE_W-1:0] vnode, unode;

  assign req      = mem_read | mem_write;
  assign hit_oh   = WAYS'(1) << hit_way;
  assign vic_oh   = WAYS'(1) << victim_q;
  assign miss_way = (~&valid) ? inv_way : plru_way;
  assign plru_d   = tree_upd[PLRU_W-1:0];

  // Lowest-index hit way and lowest-index invalid way.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (hit[i])   hit_way = WAY_W'(i);
      if (!valid[i]) inv_way = WAY_W'(i);
    end
  end

  // Walk the heap-ordered tree: follow node bits for the victim, point away from hit_way on update.
  always_comb begin
    tree     = {{(WAYS + 1){1'b0}}, plru_q[set_idx]};
    tree_upd = tree;
    plru_way = '0;
    vnode    = '0;
    unode    = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      plru_way[int'(WAY_W) - 1 - l] = tree[vnode];
      vnode = (vnode << 1) + NODE_W'(1) + NODE_W'(tree[vnode]);
      tree_upd[unode] = ~hit_way[int'(WAY_W) - 1 - l];
      unode = (unode << 1) + NODE_W'(1) + NODE_W'(hit_way[int'(WAY_W) - 1 - l]);
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    plru_we       = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = '0;
    data_we       = '0;
    data_src      = 1'b0;
    tag_load      = '0;
    valid_load    = '0;
    dirty_load    = '0;
    dirty_in      = 1'b0;
    pmem_addr_sel = 1'b0;
    unique case (state_q)
      StCompare: begin
        if (req && |hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          plru_we  = 1'b1;
          // Simultaneous read and write is treated as a write.
          if (mem_write) begin
            data_we    = hit_oh;
            dirty_load = hit_oh;
            dirty_in   = 1'b1;
          end
        end else if (req) begin
          victim_d = miss_way;
          state_d  = (valid[miss_way] && dirty[miss_way]) ? StWriteBack : StAllocate;
        end
      end
      StWriteBack: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) begin
          dirty_load = vic_oh;
          state_d    = StAllocate;
        end
      end
      StAllocate: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          data_we    = vic_oh;
          data_src   = 1'b1;
          tag_load   = vic_oh;
          valid_load = vic_oh;
          dirty_load = vic_oh;
          state_d    = StCompare;
        end
      end
      default: state_d = StCompare;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StCompare;
      victim_q <= '0;
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (plru_we) plru_q[set_idx] <= plru_d;
    end
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic was_alloc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      was_alloc_q <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      wb_cnt      <= '0;
    end else begin
      was_alloc_q <= (state_q == StAllocate);
      // Re-lookups right after a fill are completions of a miss, not hits.
      if (mem_resp && !was_alloc_q) hit_cnt <= hit_cnt + 32'd1;
      if (state_q == StCompare && state_d != StCompare) miss_cnt <= miss_cnt + 32'd1;
      if (state_q == StWriteBack && state_d != StWriteBack) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule
